down_timer: RTL and testbench

- Programmable down-counting interval timer. Complements the existing 8-bit up counter with preset load and terminal count at all-ones: this block loads a period and counts down to a terminal count at zero.
- Provides one-shot and periodic (auto-reload) modes, start/stop control, a one-cycle terminal-count pulse and a saturating expiry counter.
- Used as a tick/timeout generator for control logic alongside the up counter.

---
 rtl/down_timer_if.sv | 40 ++++
 rtl/down_timer.sv | 101 ++++++++++
 tb/tb_down_timer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/down_timer_if.sv
// Handshake bundle for the down-counting interval timer.
// Master drives control and period; slave returns count and status.
interface down_timer_if #(
    parameter int WIDTH = 8,
    parameter int EVW   = 8
);
    logic             start;
    logic             stop;
    logic             periodic;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tzero;
    logic             busy;
    logic             expired;
    logic [EVW-1:0]   events;

    modport master (
        output start,
        output stop,
        output periodic,
        output load_val,
        input  count,
        input  tzero,
        input  busy,
        input  expired,
        input  events
    );

    modport slave (
        input  start,
        input  stop,
        input  periodic,
        input  load_val,
        output count,
        output tzero,
        output busy,
        output expired,
        output events
    );
endinterface

// File: rtl/down_timer.sv
// Programmable down-counting interval timer: one-shot or auto-reload,
// one-cycle terminal-count pulse and saturating expiry counter.
module down_timer #(
    parameter int WIDTH = 8,
    parameter int EVW   = 8
) (
    input  logic        clk,
    input  logic        reset,
    down_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             tzero;
    logic             busy;
    logic             expired;
    logic [EVW-1:0]   events;

    logic             accept;
    logic             last;
    logic [EVW-1:0]   events_inc;

    // A start is only honoured with a non-zero period and no stop.
    assign accept = bus.start && !bus.stop && (bus.load_val != '0);

    // Terminal count: the next RUN edge expires the period.
    assign last = (count == WIDTH'(1));

    // Expiry counter sticks at all-ones instead of wrapping.
    assign events_inc = (events == '1) ? events : events + EVW'(1);

    // Single FSM: stop beats start, start beats expiry, outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            reload  <= '0;
            mode    <= 1'b0;
            count   <= '0;
            tzero   <= 1'b0;
            busy    <= 1'b0;
            expired <= 1'b0;
            events  <= '0;
        end else if (bus.stop) begin
            state   <= IDLE;
            count   <= '0;
            tzero   <= 1'b0;
            busy    <= 1'b0;
            expired <= 1'b0;
        end else if (accept) begin
            state   <= RUN;
            reload  <= bus.load_val;
            mode    <= bus.periodic;
            count   <= bus.load_val;
            events  <= '0;
            tzero   <= 1'b0;
            busy    <= 1'b1;
            expired <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (last) begin
                        tzero  <= 1'b1;
                        events <= events_inc;
                        if (mode) begin
                            count <= reload;
                        end else begin
                            count   <= '0;
                            state   <= DONE;
                            busy    <= 1'b0;
                            expired <= 1'b1;
                        end
                    end else begin
                        count <= count - WIDTH'(1);
                        tzero <= 1'b0;
                    end
                end
                DONE: begin
                    tzero <= 1'b0;
                end
                default: begin
                    tzero <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count   = count;
    assign bus.tzero   = tzero;
    assign bus.busy    = busy;
    assign bus.expired = expired;
    assign bus.events  = events;

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: constant vector table, directed corner cases
// and random stimulus against a behavioural model of the timer.
module tb_down_timer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    down_timer_if #(.WIDTH(8), .EVW(8)) bus ();

    down_timer #(.WIDTH(8), .EVW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // behavioural model: remaining cycles, period, run/done flags
    int m_cnt;
    int m_period;
    int m_ev;
    bit m_per;
    bit m_run;
    bit m_done;
    bit m_tz;

    typedef struct {
        logic       s;
        logic       st;
        logic       p;
        logic [7:0] ld;
        int         cnt;
        logic       tz;
        logic       bz;
        logic       ex;
        int         ev;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_period = 0; m_ev = 0;
        m_per = 0; m_run = 0; m_done = 0; m_tz = 0;
    endtask

    task automatic model_step(input logic s, input logic st,
                              input logic p, input int ld);
        if (st) begin
            m_run = 0; m_done = 0; m_cnt = 0; m_tz = 0;
        end else if (s && ld != 0) begin
            m_run = 1; m_done = 0; m_period = ld; m_per = p;
            m_cnt = ld; m_ev = 0; m_tz = 0;
        end else if (m_run) begin
            if (m_cnt == 1) begin
                m_tz = 1;
                if (m_ev < 255) m_ev = m_ev + 1;
                if (m_per) begin
                    m_cnt = m_period;
                end else begin
                    m_cnt = 0; m_run = 0; m_done = 1;
                end
            end else begin
                m_cnt = m_cnt - 1;
                m_tz = 0;
            end
        end else begin
            m_tz = 0;
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".count"}, 32'(bus.count), 32'(m_cnt));
        chk({tag, ".tzero"}, 32'(bus.tzero), 32'(m_tz));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(m_run));
        chk({tag, ".expired"}, 32'(bus.expired), 32'(m_done));
        chk({tag, ".events"}, 32'(bus.events), 32'(m_ev));
    endtask

    task automatic step(input string tag, input logic s, input logic st,
                        input logic p, input logic [7:0] ld);
        bus.start    = s;
        bus.stop     = st;
        bus.periodic = p;
        bus.load_val = ld;
        @(posedge clk);
        model_step(s, st, p, int'(ld));
        #1;
        cmp_model(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        int pulses;
        int first;
        int second;

        tbl[0] = '{1, 0, 0, 8'd5, 5, 0, 1, 0, 0};
        tbl[1] = '{0, 0, 0, 8'd0, 4, 0, 1, 0, 0};
        tbl[2] = '{0, 0, 0, 8'd0, 3, 0, 1, 0, 0};
        tbl[3] = '{0, 0, 0, 8'd0, 2, 0, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 8'd0, 1, 0, 1, 0, 0};
        tbl[5] = '{0, 0, 1, 8'd9, 0, 1, 0, 1, 1};
        tbl[6] = '{0, 0, 0, 8'd0, 0, 0, 0, 1, 1};
        tbl[7] = '{1, 0, 1, 8'd0, 0, 0, 0, 1, 1};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.periodic = 1'b0;
        bus.load_val = 8'd0;
        model_reset();
        #12;
        cmp_model("reset");
        reset = 1'b0;

        step("ld0_idle", 1'b1, 1'b0, 1'b0, 8'd0);
        idle("ld0_idle2");

        for (int i = 0; i < 8; i++) begin
            step($sformatf("vec%0d", i), tbl[i].s, tbl[i].st,
                 tbl[i].p, tbl[i].ld);
            chk($sformatf("vec%0d.count", i), 32'(bus.count),
                32'(tbl[i].cnt));
            chk($sformatf("vec%0d.tzero", i), 32'(bus.tzero),
                32'(tbl[i].tz));
            chk($sformatf("vec%0d.busy", i), 32'(bus.busy),
                32'(tbl[i].bz));
            chk($sformatf("vec%0d.expired", i), 32'(bus.expired),
                32'(tbl[i].ex));
            chk($sformatf("vec%0d.events", i), 32'(bus.events),
                32'(tbl[i].ev));
        end

        // periodic N=3 over ten cycles
        pulses = 0;
        step("per3", 1'b1, 1'b0, 1'b1, 8'd3);
        for (int i = 1; i < 10; i++) begin
            idle("per3_run");
            if (bus.tzero === 1'b1) pulses++;
            if (i == 3 || i == 6 || i == 9)
                chk("per3_pulse_at", 32'(bus.tzero), 32'd1);
        end
        chk("per3_pulses", 32'(pulses), 32'd3);
        chk("per3_events", 32'(bus.events), 32'd3);
        chk("per3_busy", 32'(bus.busy), 32'd1);

        // restart at count 2 then stop with start
        step("rst5", 1'b1, 1'b0, 1'b1, 8'd5);
        idle("rst5_a");
        idle("rst5_b");
        idle("rst5_c");
        chk("restart_pre_count", 32'(bus.count), 32'd2);
        step("restart7", 1'b1, 1'b0, 1'b0, 8'd7);
        chk("restart_count", 32'(bus.count), 32'd7);
        chk("restart_events", 32'(bus.events), 32'd0);
        chk("restart_tzero", 32'(bus.tzero), 32'd0);
        step("stop_start", 1'b1, 1'b1, 1'b1, 8'd4);
        chk("stop_start_count", 32'(bus.count), 32'd0);
        chk("stop_start_busy", 32'(bus.busy), 32'd0);

        // N=1 periodic: pulse every cycle, events saturates
        pulses = 0;
        step("per1", 1'b1, 1'b0, 1'b1, 8'd1);
        for (int i = 1; i < 300; i++) begin
            idle("per1_run");
            if (bus.tzero === 1'b1 && bus.count === 8'd1) pulses++;
        end
        chk("per1_pulses", 32'(pulses), 32'd299);
        chk("per1_sat", 32'(bus.events), 32'd255);

        // N=255 periodic: gap between pulses
        first  = -1;
        second = -1;
        step("per255", 1'b1, 1'b0, 1'b1, 8'd255);
        for (int i = 1; i < 600 && second < 0; i++) begin
            idle("per255_run");
            if (bus.tzero === 1'b1) begin
                if (first < 0) first = i;
                else second = i;
            end
        end
        chk("per255_first", 32'(first), 32'd255);
        chk("per255_gap", 32'(second - first), 32'd255);

        // async reset mid-cycle while running
        step("ar_start", 1'b1, 1'b0, 1'b0, 8'd9);
        idle("ar_run");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        cmp_model("async_reset");
        chk("async_busy", 32'(bus.busy), 32'd0);
        #3;
        reset = 1'b0;

        // stop on the terminal cycle of a one-shot
        step("stop1", 1'b1, 1'b0, 1'b0, 8'd2);
        idle("stop1_run");
        chk("stop1_pre", 32'(bus.count), 32'd1);
        step("stop1_stop", 1'b0, 1'b1, 1'b0, 8'd0);
        chk("stop1_tzero", 32'(bus.tzero), 32'd0);
        chk("stop1_expired", 32'(bus.expired), 32'd0);
        chk("stop1_busy", 32'(bus.busy), 32'd0);
        chk("stop1_events", 32'(bus.events), 32'd0);

        // start on the expiry cycle wins
        step("coll", 1'b1, 1'b0, 1'b1, 8'd2);
        idle("coll_run");
        step("coll_start", 1'b1, 1'b0, 1'b0, 8'd4);
        chk("coll_count", 32'(bus.count), 32'd4);
        chk("coll_tzero", 32'(bus.tzero), 32'd0);
        chk("coll_events", 32'(bus.events), 32'd0);

        // random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            logic s;
            logic st;
            logic p;
            logic [7:0] ld;
            s  = ($urandom % 8) == 0;
            st = ($urandom % 20) == 0;
            p  = $urandom % 2;
            ld = (($urandom % 5) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            step("rand", s, st, p, ld);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
